// File: rtl/priority_pkg.sv
// rtl/priority_pkg.sv - shared mode constants and FSM state type for the priority encoders
package priority_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/priority_encoder_n.sv
// rtl/priority_encoder_n.sv - combinational N-input encoder returning the highest set index
module priority_encoder_n #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/priority_encoder_rr.sv
// rtl/priority_encoder_rr.sv - registered N-input fixed/round-robin priority encoder with valid/ready output
module priority_encoder_rr
  import priority_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             mode,
  output logic             any_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     out_onehot
);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] base;
  logic [IDX_W-1:0] idx_dec;
  logic [IDX_W-1:0] enc_idx;
  logic [IDX_W-1:0] winner;
  logic [IDX_W:0]   shamt;
  logic [IDX_W:0]   sum;
  logic [2*N-1:0]   req2;
  logic [N-1:0]     rotated;
  logic             found;
  logic             accept;
  logic             load;

  assign any_req   = |req;
  assign out_valid = (state == ST_HOLD);
  assign accept    = out_valid && out_ready;
  assign idx_dec   = (out_idx == '0) ? IDX_W'(N - 1) : out_idx - IDX_W'(1);

  always_comb begin
    base = IDX_W'(N - 1);
    if (mode == MODE_RR) begin
      base = accept ? idx_dec : ptr;
    end
  end

  // Rotate so req[base] lands on bit N-1; the doubled vector keeps the wrap mod N.
  assign shamt   = {1'b0, base} + (IDX_W + 1)'(1);
  assign req2    = {req, req};
  assign rotated = req2[shamt +: N];

  priority_encoder_n #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_enc (
    .vec   (rotated),
    .idx   (enc_idx),
    .found (found)
  );

  assign sum    = {1'b0, enc_idx} + shamt;
  assign winner = (sum >= (IDX_W + 1)'(N)) ? IDX_W'(sum - (IDX_W + 1)'(N)) : sum[IDX_W-1:0];

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (found) begin
          state_nxt = ST_HOLD;
          load      = 1'b1;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          if (found) load = 1'b1;
          else       state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // out_idx survives the return to IDLE; only the one-hot view is cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_idx    <= '0;
      out_onehot <= '0;
      ptr        <= IDX_W'(N - 1);
    end else begin
      if (load) begin
        out_idx    <= winner;
        out_onehot <= N'(1) << winner;
      end else if (state_nxt == ST_IDLE) begin
        out_onehot <= '0;
      end
      if (accept && (mode == MODE_RR)) begin
        ptr <= idx_dec;
      end
    end
  end

endmodule

// File: tb/tb_priority_encoder_rr.sv
// tb/tb_priority_encoder_rr.sv - directed table-driven bench for priority_encoder_rr (N=8 and N=5)
module tb_priority_encoder_rr;

  typedef struct {
    logic [7:0] req;
    logic       mode;
    logic       ready;
    logic       exp_valid;
    logic [2:0] exp_idx;
    logic [7:0] exp_oh;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       mode;
  logic       ready;
  logic       any8, valid8;
  logic [2:0] idx8;
  logic [7:0] oh8;
  logic [4:0] req5;
  logic       mode5;
  logic       ready5;
  logic       any5, valid5;
  logic [2:0] idx5;
  logic [4:0] oh5;

  int checks   = 0;
  int failures = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  priority_encoder_rr #(.N(8)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .mode       (mode),
    .any_req    (any8),
    .out_valid  (valid8),
    .out_ready  (ready),
    .out_idx    (idx8),
    .out_onehot (oh8)
  );

  priority_encoder_rr #(.N(5)) dut5 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req5),
    .mode       (mode5),
    .any_req    (any5),
    .out_valid  (valid5),
    .out_ready  (ready5),
    .out_idx    (idx5),
    .out_onehot (oh5)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int       exp5[4];
    logic [4:0] exp5_oh[4];

    exp5    = '{4, 0, 4, 0};
    exp5_oh = '{5'b10000, 5'b00001, 5'b10000, 5'b00001};

    // req, mode, ready -> valid, idx, onehot
    tbl.push_back('{8'h2C, 1'b0, 1'b1, 1'b1, 3'd5, 8'h20});
    tbl.push_back('{8'h2C, 1'b0, 1'b1, 1'b1, 3'd5, 8'h20});
    tbl.push_back('{8'h2C, 1'b0, 1'b1, 1'b1, 3'd5, 8'h20});
    tbl.push_back('{8'h00, 1'b0, 1'b1, 1'b0, 3'd5, 8'h00});
    tbl.push_back('{8'h00, 1'b0, 1'b0, 1'b0, 3'd5, 8'h00});
    tbl.push_back('{8'h08, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08});
    tbl.push_back('{8'h80, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08});
    tbl.push_back('{8'h80, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08});
    tbl.push_back('{8'h80, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08});
    tbl.push_back('{8'h80, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08});
    tbl.push_back('{8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08});
    tbl.push_back('{8'h80, 1'b0, 1'b1, 1'b1, 3'd7, 8'h80});
    tbl.push_back('{8'h00, 1'b0, 1'b1, 1'b0, 3'd7, 8'h00});
    tbl.push_back('{8'hFF, 1'b1, 1'b1, 1'b1, 3'd7, 8'h80});
    tbl.push_back('{8'hFF, 1'b1, 1'b1, 1'b1, 3'd6, 8'h40});
    tbl.push_back('{8'hFF, 1'b1, 1'b1, 1'b1, 3'd5, 8'h20});
    tbl.push_back('{8'hFF, 1'b1, 1'b1, 1'b1, 3'd4, 8'h10});
    tbl.push_back('{8'hFF, 1'b1, 1'b1, 1'b1, 3'd3, 8'h08});
    tbl.push_back('{8'hFF, 1'b1, 1'b1, 1'b1, 3'd2, 8'h04});
    tbl.push_back('{8'hFF, 1'b1, 1'b1, 1'b1, 3'd1, 8'h02});
    tbl.push_back('{8'hFF, 1'b1, 1'b1, 1'b1, 3'd0, 8'h01});
    tbl.push_back('{8'hFF, 1'b1, 1'b1, 1'b1, 3'd7, 8'h80});
    tbl.push_back('{8'h01, 1'b0, 1'b0, 1'b1, 3'd7, 8'h80});
    tbl.push_back('{8'h06, 1'b0, 1'b1, 1'b1, 3'd2, 8'h04});
    tbl.push_back('{8'h06, 1'b1, 1'b1, 1'b1, 3'd1, 8'h02});
    tbl.push_back('{8'hFF, 1'b1, 1'b1, 1'b1, 3'd0, 8'h01});

    rst_n  = 1'b0;
    req    = 8'hFF;
    mode   = 1'b0;
    ready  = 1'b0;
    req5   = 5'b0;
    mode5  = 1'b1;
    ready5 = 1'b0;

    repeat (3) tick();
    check("reset valid", 32'(valid8), 32'd0);
    check("reset idx", 32'(idx8), 32'd0);
    check("reset onehot", 32'(oh8), 32'd0);
    check("reset any_req", 32'(any8), 32'd1);

    rst_n = 1'b1;
    tick();
    check("first grant valid", 32'(valid8), 32'd1);
    check("first grant idx", 32'(idx8), 32'd7);

    for (int i = 0; i < tbl.size(); i++) begin
      req   = tbl[i].req;
      mode  = tbl[i].mode;
      ready = tbl[i].ready;
      tick();
      check($sformatf("row%0d valid", i), 32'(valid8), 32'(tbl[i].exp_valid));
      check($sformatf("row%0d idx", i), 32'(idx8), 32'(tbl[i].exp_idx));
      check($sformatf("row%0d onehot", i), 32'(oh8), 32'(tbl[i].exp_oh));
      check($sformatf("row%0d any_req", i), 32'(any8), 32'(tbl[i].req != 8'h00));
    end

    // asynchronous reset while holding grant 0 with ptr=0
    ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst valid", 32'(valid8), 32'd0);
    check("async rst idx", 32'(idx8), 32'd0);
    check("async rst onehot", 32'(oh8), 32'd0);
    tick();
    rst_n = 1'b1;
    req   = 8'hFF;
    mode  = 1'b1;
    tick();
    check("post rst rr valid", 32'(valid8), 32'd1);
    check("post rst rr idx", 32'(idx8), 32'd7);

    req   = 8'h00;
    req5  = 5'b10001;
    mode5 = 1'b1;
    ready5 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("n5 rr%0d valid", i), 32'(valid5), 32'd1);
      check($sformatf("n5 rr%0d idx", i), 32'(idx5), 32'(exp5[i]));
      check($sformatf("n5 rr%0d onehot", i), 32'(oh5), 32'(exp5_oh[i]));
      check($sformatf("n5 rr%0d in range", i), 32'(idx5 < 3'd5), 32'd1);
    end

    mode5 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("n5 fixed%0d idx", i), 32'(idx5), 32'd4);
      check($sformatf("n5 fixed%0d onehot", i), 32'(oh5), 32'h10);
    end

    req5 = 5'b0;
    tick();
    check("n5 idle valid", 32'(valid5), 32'd0);
    check("n5 idle onehot", 32'(oh5), 32'd0);
    check("n5 idle idx kept", 32'(idx5), 32'd4);

    req5 = 5'b00100;
    #1;
    check("n5 any_req high", 32'(any5), 32'd1);
    req5 = 5'b00000;
    #1;
    check("n5 any_req low", 32'(any5), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
